// File: rtl/half_adder_if.sv
// Bundles the operand, result and handshake signals of half_adder_core.
// Declaration order keeps sum, cout, a, b first, matching legacy half-adder port lists.
interface half_adder_if #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CW    = $clog2(WIDTH + 1)
);
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] cout;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic             out_valid;
    logic [CW-1:0]    carry_cnt;

    // Producer of operands, consumer of results
    modport master (
        input  sum,
        input  cout,
        output a,
        output b,
        output in_valid,
        input  out_valid,
        input  carry_cnt
    );

    // The adder itself
    modport slave (
        output sum,
        output cout,
        input  a,
        input  b,
        input  in_valid,
        output out_valid,
        output carry_cnt
    );
endinterface

// File: rtl/half_adder_core.sv
// Lane-parallel 1-bit half adder with optional output register stage.
// Each lane is independent: sum = a ^ b, cout = a & b. carry_cnt counts set cout lanes.
module half_adder_core #(
    parameter int unsigned WIDTH      = 1,
    parameter bit          REGISTERED = 1'b1,
    localparam int unsigned CW        = $clog2(WIDTH + 1)
) (
    input logic         clk,
    input logic         rst_n,
    half_adder_if.slave bus
);

    // Number of set bits; CW is sized so that WIDTH itself fits.
    function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    logic [WIDTH-1:0] sum_c;
    logic [WIDTH-1:0] cout_c;
    logic [CW-1:0]    cnt_c;

    // Per-lane half-adder results and their carry count
    always_comb begin
        sum_c  = bus.a ^ bus.b;
        cout_c = bus.a & bus.b;
        cnt_c  = popcount(cout_c);
    end

    if (REGISTERED) begin : gen_reg
        logic [WIDTH-1:0] sum_q,  sum_d;
        logic [WIDTH-1:0] cout_q, cout_d;
        logic [CW-1:0]    cnt_q,  cnt_d;
        logic             valid_q, valid_d;

        // Capture only on in_valid so junk (even X) on idle operands never reaches the outputs
        always_comb begin
            sum_d   = sum_q;
            cout_d  = cout_q;
            cnt_d   = cnt_q;
            valid_d = bus.in_valid;
            if (bus.in_valid) begin
                sum_d  = sum_c;
                cout_d = cout_c;
                cnt_d  = cnt_c;
            end
        end

        // Result register; async reset drops any pending result
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q   <= '0;
                cout_q  <= '0;
                cnt_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                sum_q   <= sum_d;
                cout_q  <= cout_d;
                cnt_q   <= cnt_d;
                valid_q <= valid_d;
            end
        end

        // Drive registered results onto the bus
        always_comb begin
            bus.sum       = sum_q;
            bus.cout      = cout_q;
            bus.carry_cnt = cnt_q;
            bus.out_valid = valid_q;
        end
    end else begin : gen_comb
        logic unused_clk;
        assign unused_clk = clk;

        // Bypass path; reset still forces every output low
        always_comb begin
            bus.sum       = rst_n ? sum_c  : '0;
            bus.cout      = rst_n ? cout_c : '0;
            bus.carry_cnt = rst_n ? cnt_c  : '0;
            bus.out_valid = bus.in_valid & rst_n;
        end
    end

    // carry_cnt must always agree with the cout it is published alongside
    a_cnt_consistent : assert property (@(posedge clk) disable iff (!rst_n)
        bus.carry_cnt == CW'($countones(bus.cout)));

endmodule

// File: tb/tb_half_adder_core.sv
// Self-checking bench for half_adder_core: a registered 1-lane, a registered 8-lane
// and a combinational 8-lane instance, checked by vector tables, hand sequences
// and random stimulus against an arithmetic reference model.
module tb_half_adder_core;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    half_adder_if #(.WIDTH(1)) bus1 ();
    half_adder_if #(.WIDTH(8)) bus8 ();
    half_adder_if #(.WIDTH(8)) busc ();

    half_adder_core #(.WIDTH(1), .REGISTERED(1'b1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    half_adder_core #(.WIDTH(8), .REGISTERED(1'b1)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    half_adder_core #(.WIDTH(8), .REGISTERED(1'b0)) u_dutc (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       iv;
        logic [7:0] esum;
        logic [7:0] ecout;
        logic [3:0] ecnt;
        logic       evalid;
    } vec_t;

    vec_t v1[$];
    vec_t v8[$];

    // Reference model state for the registered 8-lane instance
    logic [7:0] m_sum;
    logic [7:0] m_cout;
    int         m_cnt;
    logic       m_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-lane arithmetic: the two-bit total of a lane is {cout, sum}
    function automatic void ref_add(input logic [7:0] a, input logic [7:0] b,
                                    output logic [7:0] s, output logic [7:0] c,
                                    output int n);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            int t;
            t    = int'(a[i]) + int'(b[i]);
            s[i] = (t % 2) == 1;
            c[i] = t >= 2;
            n    = n + t / 2;
        end
    endfunction

    task automatic model8_step(input logic [7:0] a, input logic [7:0] b, input logic iv);
        if (iv) ref_add(a, b, m_sum, m_cout, m_cnt);
        m_valid = iv;
    endtask

    task automatic model_reset();
        m_sum   = '0;
        m_cout  = '0;
        m_cnt   = 0;
        m_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] rs;
        logic [7:0] rc;
        int         rn;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       riv;

        checks = 0;
        errors = 0;
        model_reset();

        // W1 table: truth table then hold (in_valid=0, a=0 b=1 must not disturb)
        v1.push_back('{8'h0, 8'h0, 1'b1, 8'h0, 8'h0, 4'd0, 1'b1});
        v1.push_back('{8'h0, 8'h1, 1'b1, 8'h1, 8'h0, 4'd0, 1'b1});
        v1.push_back('{8'h1, 8'h0, 1'b1, 8'h1, 8'h0, 4'd0, 1'b1});
        v1.push_back('{8'h1, 8'h1, 1'b1, 8'h0, 8'h1, 4'd1, 1'b1});
        v1.push_back('{8'h0, 8'h1, 1'b0, 8'h0, 8'h1, 4'd1, 1'b0});

        // W8 table
        v8.push_back('{8'hF0, 8'hCC, 1'b1, 8'h3C, 8'hC0, 4'd2, 1'b1});
        v8.push_back('{8'hFF, 8'hFF, 1'b1, 8'h00, 8'hFF, 4'd8, 1'b1});
        v8.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 8'hFF, 4'd8, 1'b0});
        v8.push_back('{8'hAA, 8'h55, 1'b1, 8'hFF, 8'h00, 4'd0, 1'b1});
        v8.push_back('{8'h0F, 8'h0F, 1'b1, 8'h00, 8'h0F, 4'd4, 1'b1});
        v8.push_back('{8'h81, 8'hC3, 1'b1, 8'h42, 8'h81, 4'd2, 1'b1});

        // Reset phase; the comb instance sees live operands but must stay at 0
        rst_n         = 1'b0;
        bus1.a        = '0;
        bus1.b        = '0;
        bus1.in_valid = 1'b0;
        bus8.a        = '0;
        bus8.b        = '0;
        bus8.in_valid = 1'b0;
        busc.a        = 8'hFF;
        busc.b        = 8'hFF;
        busc.in_valid = 1'b1;
        #3;
        check("rst_w8_sum",   32'(bus8.sum),       32'h0);
        check("rst_w8_cout",  32'(bus8.cout),      32'h0);
        check("rst_w8_cnt",   32'(bus8.carry_cnt), 32'h0);
        check("rst_w8_valid", 32'(bus8.out_valid), 32'h0);
        check("rst_w1_valid", 32'(bus1.out_valid), 32'h0);
        check("rst_comb_cout",  32'(busc.cout),      32'h0);
        check("rst_comb_valid", 32'(busc.out_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // W1 truth table and hold
        foreach (v1[i]) begin
            @(negedge clk);
            bus1.a        = v1[i].a[0];
            bus1.b        = v1[i].b[0];
            bus1.in_valid = v1[i].iv;
            @(posedge clk);
            #1;
            check($sformatf("w1_sum[%0d]", i),   32'(bus1.sum),       32'(v1[i].esum[0]));
            check($sformatf("w1_cout[%0d]", i),  32'(bus1.cout),      32'(v1[i].ecout[0]));
            check($sformatf("w1_cnt[%0d]", i),   32'(bus1.carry_cnt), 32'(v1[i].ecnt[0]));
            check($sformatf("w1_valid[%0d]", i), 32'(bus1.out_valid), 32'(v1[i].evalid));
        end

        // W8 table
        foreach (v8[i]) begin
            @(negedge clk);
            bus8.a        = v8[i].a;
            bus8.b        = v8[i].b;
            bus8.in_valid = v8[i].iv;
            model8_step(v8[i].a, v8[i].b, v8[i].iv);
            @(posedge clk);
            #1;
            check($sformatf("w8_sum[%0d]", i),   32'(bus8.sum),       32'(v8[i].esum));
            check($sformatf("w8_cout[%0d]", i),  32'(bus8.cout),      32'(v8[i].ecout));
            check($sformatf("w8_cnt[%0d]", i),   32'(bus8.carry_cnt), 32'(v8[i].ecnt));
            check($sformatf("w8_valid[%0d]", i), 32'(bus8.out_valid), 32'(v8[i].evalid));
        end

        // X on idle operands must not reach the registered outputs
        @(negedge clk);
        bus8.a        = 'x;
        bus8.b        = 'x;
        bus8.in_valid = 1'b0;
        model8_step(8'h00, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        check("xhold_sum",   32'(bus8.sum),       32'(m_sum));
        check("xhold_cout",  32'(bus8.cout),      32'(m_cout));
        check("xhold_valid", 32'(bus8.out_valid), 32'(m_valid));

        // Combinational instance: lane 0 with a=1 b=0 in the same cycle
        @(negedge clk);
        busc.a        = 8'h01;
        busc.b        = 8'h00;
        busc.in_valid = 1'b1;
        #1;
        check("comb_sum",   32'(busc.sum),       32'h01);
        check("comb_cout",  32'(busc.cout),      32'h00);
        check("comb_valid", 32'(busc.out_valid), 32'h1);

        // Async reset between edges with a live result, then release with in_valid=0
        @(negedge clk);
        bus1.a        = 1'b1;
        bus1.b        = 1'b0;
        bus1.in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("prerst_sum",   32'(bus1.sum),       32'h1);
        check("prerst_valid", 32'(bus1.out_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_sum",   32'(bus1.sum),       32'h0);
        check("async_rst_cout",  32'(bus1.cout),      32'h0);
        check("async_rst_valid", 32'(bus1.out_valid), 32'h0);
        check("async_rst_comb",  32'(busc.out_valid), 32'h0);
        @(negedge clk);
        bus1.in_valid = 1'b0;
        bus8.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_valid", 32'(bus1.out_valid), 32'h0);
        check("postrst_sum",   32'(bus1.sum),       32'h0);

        // Random stimulus on both 8-lane instances
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            riv = 1'($urandom_range(0, 3) != 0);
            bus8.a        = ra;
            bus8.b        = rb;
            bus8.in_valid = riv;
            busc.a        = rb;
            busc.b        = ra ^ rb;
            busc.in_valid = riv;
            model8_step(ra, rb, riv);
            #1;
            ref_add(rb, ra ^ rb, rs, rc, rn);
            check("rnd_comb_sum",   32'(busc.sum),       32'(rs));
            check("rnd_comb_cout",  32'(busc.cout),      32'(rc));
            check("rnd_comb_cnt",   32'(busc.carry_cnt), 32'(rn));
            check("rnd_comb_valid", 32'(busc.out_valid), 32'(riv));
            @(posedge clk);
            #1;
            check("rnd_w8_sum",   32'(bus8.sum),       32'(m_sum));
            check("rnd_w8_cout",  32'(bus8.cout),      32'(m_cout));
            check("rnd_w8_cnt",   32'(bus8.carry_cnt), 32'(m_cnt));
            check("rnd_w8_valid", 32'(bus8.out_valid), 32'(m_valid));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
